panda_writeback_stage: RTL and testbench
========================================

Name: panda_writeback_stage

Overview:
- Final pipeline stage of the Panda core; drives the rd write port of the register file.
- Accepts retiring instructions from the memory stage through a valid/ready handshake.
- ALU/jump results are forwarded directly. Loads stall until the data-memory response arrives, then the response is aligned and sign/zero-extended.
- Write-port outputs are registered, so each write reaches the register file exactly one cycle after the stage completes the instruction.

Parameters:
- None. Widths are fixed by RV32I: XLEN 32, register address 5.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
wb_valid_i  input  1  memory stage presents an instruction
wb_ready_o  output  1  stage can accept an instruction this cycle
rd_addr_i  input  5  destination register of the presented instruction
rd_we_i  input  1  instruction writes rd
result_i  input  32  ALU/jump result (ignored for loads)
load_i  input  1  instruction is a load
load_type_i  input  3  load funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101
addr_lsb_i  input  2  load byte address bits [1:0]
data_rvalid_i  input  1  data-memory response valid
data_rdata_i  input  32  data-memory response word (word-aligned)
data_err_i  input  1  response carries a bus error (qualified by data_rvalid_i)
rd_addr_o  output  5  register file write address
rd_data_o  output  32  register file write data
rd_we_o  output  1  register file write enable
retire_o  output  1  one-cycle pulse per completed instruction
load_err_o  output  1  one-cycle pulse: load completed with bus error, no write

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE; rd_we_o 0; rd_addr_o 0; rd_data_o 0; retire_o 0; load_err_o 0. Held load context is cleared. Reset during WAIT_LOAD abandons the load, and a later data_rvalid_i is ignored.
- FSM state IDLE: wb_ready_o = 1. Acceptance occurs when wb_valid_i && wb_ready_o.
  - Non-load accepted: next cycle rd_we_o = rd_we_i && (rd_addr_i != 0), rd_addr_o = rd_addr_i, rd_data_o = result_i, retire_o = 1. Stay in IDLE. Throughput is 1 instruction per cycle back-to-back.
  - Load accepted: capture rd_addr_i, rd_we_i, load_type_i and addr_lsb_i, then go to WAIT_LOAD.
- FSM state WAIT_LOAD: wb_ready_o = 0. wb_valid_i is ignored; upstream holds it.
  - On data_rvalid_i && !data_err_i: next cycle rd_we_o = held_we && (held_rd != 0), rd_data_o = aligned data, retire_o = 1, return to IDLE.
  - On data_rvalid_i && data_err_i: next cycle rd_we_o = 0, load_err_o = 1, retire_o = 0, rd_addr_o = held_rd, return to IDLE.
  - On the return cycle wb_ready_o is 1 again, so a new instruction can be accepted in the cycle after the response.
- data_rvalid_i is sampled only in WAIT_LOAD and ignored in IDLE. Memory never responds in the acceptance cycle.
- Alignment, with byte = rdata >> (8*addr_lsb) and half = rdata >> (16*addr_lsb[1]):
  - LB: sign-extend byte[7:0]. LBU: zero-extend byte[7:0].
  - LH: sign-extend half[15:0]. LHU: zero-extend half[15:0]. addr_lsb[0] is ignored for halfwords.
  - LW: full word; addr_lsb is ignored.
  - Undefined funct3 (011, 110, 111) is treated as LW.
- Outputs when not completing: rd_we_o, retire_o and load_err_o are 0. rd_addr_o and rd_data_o hold their last values.
- Write to x0: the stage itself never asserts rd_we_o for address 0. retire_o still pulses.

Decomposition:
- panda_pkg:
  - load_type_e enum (LB, LH, LW, LBU, LHU; 3-bit, funct3 encodings).
  - wb_state_e enum (IDLE, WAIT_LOAD).
  - XLEN = 32, REG_ADDR_W = 5.
- Sub-module panda_load_align: purely combinational. Inputs rdata, load_type, addr_lsb; output aligned 32-bit data. Verified standalone exhaustively over type × lsb.

Test Plan:
- Reset then idle: rst_ni low mid-cycle -> all outputs 0 immediately; wb_ready_o 1 after release.
- Back-to-back ALU instructions: accept x5=0x0000_1234 and x6=0xDEAD_BEEF on consecutive cycles -> rd_we_o on the next two consecutive cycles with matching address/data; retire_o pulses twice.
- LB sign extension: load x7, LB, lsb=2; after 3 wait cycles rvalid with rdata 0x1180_FF22 -> one cycle later rd_data_o 0xFFFF_FF80, rd_we_o 1; wb_ready_o 0 throughout the wait.
- LHU upper half: lsb=3, rdata 0x8001_0000 -> rd_data_o 0x0000_8001. LH with the same stimulus -> 0xFFFF_8001.
- Bus error plus x0: load x9 with data_err_i=1 -> load_err_o pulse, rd_we_o 0, rd_addr_o 9. ALU write to x0 -> rd_we_o 0, retire_o 1.
- Reset mid-load: assert rst_ni low in WAIT_LOAD, release, then a stray rvalid with rdata 0xFFFF_FFFF -> no write, no pulses, state stays IDLE.

Source files
------------

// File: rtl/panda_pkg.sv
// Shared types and widths for the Panda core writeback stage.
package panda_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Load funct3 encodings; 011, 110 and 111 are not defined and read as LW.
    typedef enum logic [2:0] {
        LT_LB  = 3'b000,
        LT_LH  = 3'b001,
        LT_LW  = 3'b010,
        LT_LBU = 3'b100,
        LT_LHU = 3'b101
    } load_type_e;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/panda_load_align.sv
// Combinational load-data alignment: selects the addressed byte or halfword
// from a word-aligned memory response and sign/zero-extends it.
module panda_load_align
    import panda_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      load_type_i,
    input  logic [1:0]      addr_lsb_i,
    output logic [XLEN-1:0] aligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes out of the response word.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lsb_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // Halfwords ignore addr_lsb[0]; only the upper/lower half matters.
        half_sel = addr_lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend the selected lane according to the load type; unknown types act as LW.
    always_comb begin
        aligned_o = rdata_i;
        case (load_type_i)
            LT_LB:   aligned_o = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  aligned_o = {24'h000000, byte_sel};
            LT_LH:   aligned_o = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  aligned_o = {16'h0000, half_sel};
            default: aligned_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/panda_writeback_stage.sv
// Panda core writeback stage: retires instructions from the memory stage and
// drives the register-file write port through registered outputs. Loads park
// in WAIT_LOAD until the data-memory response returns.
module panda_writeback_stage
    import panda_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wb_valid_i,
    output logic                  wb_ready_o,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_we_i,
    input  logic [XLEN-1:0]       result_i,
    input  logic                  load_i,
    input  logic [2:0]            load_type_i,
    input  logic [1:0]            addr_lsb_i,
    input  logic                  data_rvalid_i,
    input  logic [XLEN-1:0]       data_rdata_i,
    input  logic                  data_err_i,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  rd_we_o,
    output logic                  retire_o,
    output logic                  load_err_o
);

    wb_state_e             state_q, state_d;

    // Context of the load waiting for its response.
    logic [REG_ADDR_W-1:0] held_rd_q, held_rd_d;
    logic                  held_we_q, held_we_d;
    logic [2:0]            held_type_q, held_type_d;
    logic [1:0]            held_lsb_q, held_lsb_d;

    // Registered write-port and status outputs.
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       rd_data_q, rd_data_d;
    logic                  rd_we_q, rd_we_d;
    logic                  retire_q, retire_d;
    logic                  load_err_q, load_err_d;

    logic [XLEN-1:0]       load_data;

    panda_load_align u_align (
        .rdata_i     (data_rdata_i),
        .load_type_i (held_type_q),
        .addr_lsb_i  (held_lsb_q),
        .aligned_o   (load_data)
    );

    assign wb_ready_o = (state_q == WB_IDLE);

    // Next-state and next-output logic; pulses default low, write port holds.
    always_comb begin
        state_d     = state_q;
        held_rd_d   = held_rd_q;
        held_we_d   = held_we_q;
        held_type_d = held_type_q;
        held_lsb_d  = held_lsb_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        rd_we_d     = 1'b0;
        retire_d    = 1'b0;
        load_err_d  = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (wb_valid_i) begin
                    if (load_i) begin
                        held_rd_d   = rd_addr_i;
                        held_we_d   = rd_we_i;
                        held_type_d = load_type_i;
                        held_lsb_d  = addr_lsb_i;
                        state_d     = WB_WAIT_LOAD;
                    end else begin
                        // x0 is hardwired zero, so it is never written.
                        rd_we_d   = rd_we_i && (rd_addr_i != '0);
                        rd_addr_d = rd_addr_i;
                        rd_data_d = result_i;
                        retire_d  = 1'b1;
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (data_rvalid_i) begin
                    rd_addr_d = held_rd_q;
                    state_d   = WB_IDLE;
                    if (data_err_i) begin
                        load_err_d = 1'b1;
                    end else begin
                        rd_we_d   = held_we_q && (held_rd_q != '0);
                        rd_data_d = load_data;
                        retire_d  = 1'b1;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // State, held load context and registered outputs; reset abandons any pending load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WB_IDLE;
            held_rd_q   <= '0;
            held_we_q   <= 1'b0;
            held_type_q <= '0;
            held_lsb_q  <= '0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            rd_we_q     <= 1'b0;
            retire_q    <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_rd_q   <= held_rd_d;
            held_we_q   <= held_we_d;
            held_type_q <= held_type_d;
            held_lsb_q  <= held_lsb_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            rd_we_q     <= rd_we_d;
            retire_q    <= retire_d;
            load_err_q  <= load_err_d;
        end
    end

    assign rd_addr_o  = rd_addr_q;
    assign rd_data_o  = rd_data_q;
    assign rd_we_o    = rd_we_q;
    assign retire_o   = retire_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_panda_writeback_stage.sv
// Directed bench for panda_writeback_stage with hand-computed expectations.
module tb_panda_writeback_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic [31:0] result_i;
    logic        load_i;
    logic [2:0]  load_type_i;
    logic [1:0]  addr_lsb_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_we_o;
    logic        retire_o;
    logic        load_err_o;

    int total = 0;
    int bad   = 0;

    panda_writeback_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wb_valid_i    (wb_valid_i),
        .wb_ready_o    (wb_ready_o),
        .rd_addr_i     (rd_addr_i),
        .rd_we_i       (rd_we_i),
        .result_i      (result_i),
        .load_i        (load_i),
        .load_type_i   (load_type_i),
        .addr_lsb_i    (addr_lsb_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .data_err_i    (data_err_i),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o),
        .rd_we_o       (rd_we_o),
        .retire_o      (retire_o),
        .load_err_o    (load_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid_i    = 1'b0;
        rd_addr_i     = 5'd0;
        rd_we_i       = 1'b0;
        result_i      = 32'h0;
        load_i        = 1'b0;
        load_type_i   = 3'b000;
        addr_lsb_i    = 2'b00;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        data_err_i    = 1'b0;
    endtask

    task automatic present_alu(input logic [4:0] rd, input logic we, input logic [31:0] res);
        wb_valid_i = 1'b1;
        load_i     = 1'b0;
        rd_addr_i  = rd;
        rd_we_i    = we;
        result_i   = res;
    endtask

    // Accept a load, wait 'waits' cycles checking the stall, then deliver the response.
    task automatic run_load(input string tag, input logic [4:0] rd, input logic [2:0] lt,
                            input logic [1:0] lsb, input logic [31:0] rdata,
                            input logic err, input int waits);
        wb_valid_i  = 1'b1;
        load_i      = 1'b1;
        rd_addr_i   = rd;
        rd_we_i     = 1'b1;
        load_type_i = lt;
        addr_lsb_i  = lsb;
        result_i    = 32'hA5A5_A5A5;
        tick();
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_wait_ready"}, {31'b0, wb_ready_o}, 32'd0);
            chk({tag, "_wait_we"}, {31'b0, rd_we_o}, 32'd0);
            tick();
        end
        wb_valid_i    = 1'b0;
        load_i        = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = rdata;
        data_err_i    = err;
        tick();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        chk("rst_we", {31'b0, rd_we_o}, 32'd0);
        chk("rst_addr", {27'b0, rd_addr_o}, 32'd0);
        chk("rst_data", rd_data_o, 32'd0);
        chk("rst_retire", {31'b0, retire_o}, 32'd0);
        chk("rst_lerr", {31'b0, load_err_o}, 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("idle_ready", {31'b0, wb_ready_o}, 32'd1);

        // Back-to-back ALU results.
        present_alu(5'd5, 1'b1, 32'h0000_1234);
        tick();
        chk("alu1_we", {31'b0, rd_we_o}, 32'd1);
        chk("alu1_addr", {27'b0, rd_addr_o}, 32'd5);
        chk("alu1_data", rd_data_o, 32'h0000_1234);
        chk("alu1_retire", {31'b0, retire_o}, 32'd1);
        present_alu(5'd6, 1'b1, 32'hDEAD_BEEF);
        tick();
        chk("alu2_we", {31'b0, rd_we_o}, 32'd1);
        chk("alu2_addr", {27'b0, rd_addr_o}, 32'd6);
        chk("alu2_data", rd_data_o, 32'hDEAD_BEEF);
        chk("alu2_retire", {31'b0, retire_o}, 32'd1);
        idle_inputs();
        tick();
        chk("hold_we", {31'b0, rd_we_o}, 32'd0);
        chk("hold_retire", {31'b0, retire_o}, 32'd0);
        chk("hold_addr", {27'b0, rd_addr_o}, 32'd6);
        chk("hold_data", rd_data_o, 32'hDEAD_BEEF);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_addr", {27'b0, rd_addr_o}, 32'd0);
        chk("arst_data", rd_data_o, 32'd0);
        #1 rst_ni = 1'b1;
        tick();
        chk("arst_ready", {31'b0, wb_ready_o}, 32'd1);

        // LB sign extension, 3 wait cycles.
        run_load("lb", 5'd7, 3'b000, 2'd2, 32'h1180_FF22, 1'b0, 3);
        chk("lb_we", {31'b0, rd_we_o}, 32'd1);
        chk("lb_addr", {27'b0, rd_addr_o}, 32'd7);
        chk("lb_data", rd_data_o, 32'hFFFF_FF80);
        chk("lb_retire", {31'b0, retire_o}, 32'd1);
        chk("lb_ready", {31'b0, wb_ready_o}, 32'd1);
        tick();

        run_load("lhu", 5'd8, 3'b101, 2'd3, 32'h8001_0000, 1'b0, 1);
        chk("lhu_data", rd_data_o, 32'h0000_8001);
        run_load("lh", 5'd8, 3'b001, 2'd3, 32'h8001_0000, 1'b0, 1);
        chk("lh_data", rd_data_o, 32'hFFFF_8001);
        run_load("lbu", 5'd11, 3'b100, 2'd1, 32'h1180_FF22, 1'b0, 0);
        chk("lbu_data", rd_data_o, 32'h0000_00FF);
        run_load("lw", 5'd12, 3'b010, 2'd1, 32'h1234_5678, 1'b0, 0);
        chk("lw_data", rd_data_o, 32'h1234_5678);
        run_load("ft111", 5'd13, 3'b111, 2'd2, 32'h8765_4321, 1'b0, 0);
        chk("ft111_data", rd_data_o, 32'h8765_4321);

        // Bus error: no write, error pulse, address reported.
        run_load("err", 5'd9, 3'b010, 2'd0, 32'hCAFE_F00D, 1'b1, 2);
        chk("err_lerr", {31'b0, load_err_o}, 32'd1);
        chk("err_we", {31'b0, rd_we_o}, 32'd0);
        chk("err_retire", {31'b0, retire_o}, 32'd0);
        chk("err_addr", {27'b0, rd_addr_o}, 32'd9);
        chk("err_data_hold", rd_data_o, 32'h8765_4321);
        tick();
        chk("err_lerr_pulse", {31'b0, load_err_o}, 32'd0);

        // ALU write to x0 retires without writing.
        present_alu(5'd0, 1'b1, 32'h0000_0055);
        tick();
        idle_inputs();
        chk("x0_we", {31'b0, rd_we_o}, 32'd0);
        chk("x0_retire", {31'b0, retire_o}, 32'd1);
        tick();

        // Reset during WAIT_LOAD abandons the load; a stray response is ignored.
        wb_valid_i  = 1'b1;
        load_i      = 1'b1;
        rd_addr_i   = 5'd10;
        rd_we_i     = 1'b1;
        load_type_i = 3'b010;
        tick();
        idle_inputs();
        chk("mid_wait_ready", {31'b0, wb_ready_o}, 32'd0);
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk("mid_rst_ready", {31'b0, wb_ready_o}, 32'd1);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFF_FFFF;
        tick();
        data_rvalid_i = 1'b0;
        chk("stray_we", {31'b0, rd_we_o}, 32'd0);
        chk("stray_retire", {31'b0, retire_o}, 32'd0);
        chk("stray_lerr", {31'b0, load_err_o}, 32'd0);
        chk("stray_data", rd_data_o, 32'd0);
        chk("stray_ready", {31'b0, wb_ready_o}, 32'd1);
        tick();
        chk("stray_we2", {31'b0, rd_we_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
